umtrx_rx_pkt_mux: RTL and testbench

//  Packet-atomic round-robin merger of the per-DSP RX VITA streams on the sys clock domain. Sits

---
 rtl/umtrx_rx_pkt_mux_pkg.sv | 30 +++
 rtl/umtrx_rx_pkt_mux_if.sv | 31 +++
 rtl/umtrx_rx_pkt_mux_skid_buf.sv | 86 ++++++++
 rtl/umtrx_rx_pkt_mux.sv | 151 +++++++++++++++
 tb/tb_umtrx_rx_pkt_mux.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/umtrx_rx_pkt_mux_pkg.sv
// Shared VITA stream constants, FSM state type and small word helpers for
// the RX packet mux.
package umtrx_rx_pkt_mux_pkg;

    // VITA stream word layout: [31:0] data, [32] SOF, [33] EOF, [35:34] occupancy
    localparam int VITA_W  = 36;
    localparam int SOF_BIT = 32;
    localparam int EOF_BIT = 33;
    localparam int OCC_LSB = 34;

    // Settings-bus offsets relative to the block base address
    localparam int MUX_MASK = 0;
    localparam int MUX_CLR  = 1;

    typedef logic [VITA_W-1:0] vita_word_t;

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PASS = 1'b1
    } mux_state_e;

    function automatic logic is_sof(input vita_word_t w);
        return w[SOF_BIT];
    endfunction

    function automatic logic is_eof(input vita_word_t w);
        return w[EOF_BIT];
    endfunction

endpackage

// File: rtl/umtrx_rx_pkt_mux_if.sv
// Bus bundle for the RX packet mux: per-channel input streams, merged output
// stream, settings bus and status readback.
interface umtrx_rx_pkt_mux_if
    import umtrx_rx_pkt_mux_pkg::*;
#(
    parameter int NUM_CHAN = 2
);
    logic [VITA_W*NUM_CHAN-1:0] in_data;
    logic [NUM_CHAN-1:0]        in_valid;
    logic [NUM_CHAN-1:0]        in_ready;
    logic [VITA_W-1:0]          out_data;
    logic                       out_valid;
    logic                       out_ready;
    logic                       set_stb;
    logic [7:0]                 set_addr;
    logic [31:0]                set_data;
    logic [31:0]                status;

    // Mux side of the bundle
    modport slave (
        input  in_data, in_valid, out_ready, set_stb, set_addr, set_data,
        output in_ready, out_data, out_valid, status
    );

    // Environment side of the bundle (sources, sink, settings master)
    modport master (
        output in_data, in_valid, out_ready, set_stb, set_addr, set_data,
        input  in_ready, out_data, out_valid, status
    );

endinterface

// File: rtl/umtrx_rx_pkt_mux_skid_buf.sv
// Two-entry output skid buffer. Both in_ready and out_valid/out_data come
// straight from flops, so there is no combinational path from out_ready back
// to in_ready while a full word per cycle can still stream through.
module pkt_skid_buf
    import umtrx_rx_pkt_mux_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  vita_word_t in_data_i,
    input  logic       in_valid_i,
    output logic       in_ready_o,
    output vita_word_t out_data_o,
    output logic       out_valid_o,
    input  logic       out_ready_i
);

    vita_word_t head_q, head_d;
    vita_word_t tail_q, tail_d;
    logic [1:0] cnt_q, cnt_d;
    logic       rdy_q, rdy_d;
    logic       vld_q, vld_d;
    logic       push_s, pop_s;

    // Next-state of the two-entry queue; head is always the presented word
    always_comb begin
        push_s = in_valid_i & rdy_q;
        pop_s  = vld_q & out_ready_i;
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        case ({push_s, pop_s})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = in_data_i;
                end else begin
                    tail_d = in_data_i;
                end
                cnt_d = cnt_q + 2'd1;
            end
            2'b01: begin
                if (cnt_q == 2'd2) begin
                    head_d = tail_q;
                end else begin
                    head_d = head_q;
                end
                cnt_d = cnt_q - 2'd1;
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = in_data_i;
                end else begin
                    head_d = tail_q;
                    tail_d = in_data_i;
                end
                cnt_d = cnt_q;
            end
            default: begin
                cnt_d = cnt_q;
            end
        endcase
        rdy_d = (cnt_d != 2'd2);
        vld_d = (cnt_d != 2'd0);
    end

    // Queue storage and registered handshake flags
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
            rdy_q  <= 1'b0;
            vld_q  <= 1'b0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
            rdy_q  <= rdy_d;
            vld_q  <= vld_d;
        end
    end

    assign in_ready_o  = rdy_q;
    assign out_valid_o = vld_q;
    assign out_data_o  = head_q;

endmodule

// File: rtl/umtrx_rx_pkt_mux.sv
// Packet-atomic round-robin merger of the per-DSP RX VITA streams. A channel
// is granted for a whole SOF..EOF packet; the settings bus provides a channel
// enable mask and a clear for the packet counter and sticky protocol error.
module umtrx_rx_pkt_mux
    import umtrx_rx_pkt_mux_pkg::*;
#(
    parameter int NUM_CHAN = 2,
    parameter int BASE     = 0
)(
    input  logic                 sys_clk_i,
    input  logic                 sys_rst_n_i,
    umtrx_rx_pkt_mux_if.slave    bus
);

    mux_state_e          state_q;
    logic [1:0]          grant_q;
    logic [1:0]          rr_q;
    logic [NUM_CHAN-1:0] mask_q;
    logic [15:0]         pkt_cnt_q;
    logic                err_q;
    logic                first_q;

    logic [3:0]          cand_s;
    logic [1:0]          pick_s;
    logic [1:0]          rr_next_s;
    vita_word_t          sel_data_s;
    logic                sel_valid_s;
    logic                pass_s;
    logic                skid_rdy_s;
    logic                xfer_s;
    logic                wr_mask_s;
    logic                wr_clr_s;
    logic [NUM_CHAN-1:0] in_ready_s;

    // First requesting channel at or after ptr, wrapping modulo NUM_CHAN
    function automatic logic [1:0] rr_pick(input logic [3:0] cand, input logic [1:0] ptr);
        logic [1:0] pick;
        logic [1:0] c;
        logic       found;
        pick  = ptr;
        found = 1'b0;
        for (int i = 0; i < NUM_CHAN; i++) begin
            c = 2'((int'(ptr) + i) % NUM_CHAN);
            if (!found && cand[c]) begin
                pick  = c;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    // Arbitration inputs, granted-channel select and settings decode
    always_comb begin
        pass_s      = (state_q == ST_PASS);
        cand_s      = 4'(bus.in_valid & mask_q);
        pick_s      = rr_pick(cand_s, rr_q);
        sel_data_s  = '0;
        sel_valid_s = 1'b0;
        for (int k = 0; k < NUM_CHAN; k++) begin
            sel_data_s  = (grant_q == 2'(k)) ? bus.in_data[k*VITA_W +: VITA_W] : sel_data_s;
            sel_valid_s = (grant_q == 2'(k)) ? bus.in_valid[k] : sel_valid_s;
            in_ready_s[k] = pass_s & (grant_q == 2'(k)) & skid_rdy_s;
        end
        xfer_s = pass_s & sel_valid_s & skid_rdy_s;
        if (({1'b0, grant_q} + 3'd1) >= 3'(NUM_CHAN)) begin
            rr_next_s = 2'd0;
        end else begin
            rr_next_s = grant_q + 2'd1;
        end
        wr_mask_s = bus.set_stb & (bus.set_addr == 8'(BASE + MUX_MASK));
        wr_clr_s  = bus.set_stb & (bus.set_addr == 8'(BASE + MUX_CLR));
    end

    // Channel enable mask; a change only affects the next IDLE decision
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            mask_q <= {NUM_CHAN{1'b1}};
        end else if (wr_mask_s) begin
            mask_q <= bus.set_data[NUM_CHAN-1:0];
        end else begin
            mask_q <= mask_q;
        end
    end

    // Grant FSM with packet counter and sticky error; a clear write overrides
    // a same-cycle increment because it is the last assignment
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q   <= ST_IDLE;
            grant_q   <= 2'd0;
            rr_q      <= 2'd0;
            pkt_cnt_q <= 16'd0;
            err_q     <= 1'b0;
            first_q   <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (|cand_s) begin
                        grant_q <= pick_s;
                        first_q <= 1'b1;
                        state_q <= ST_PASS;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_PASS: begin
                    if (xfer_s) begin
                        first_q <= 1'b0;
                        // SOF must be set on the first word and only there
                        if (first_q != is_sof(sel_data_s)) begin
                            err_q <= 1'b1;
                        end
                        if (is_eof(sel_data_s)) begin
                            state_q   <= ST_IDLE;
                            rr_q      <= rr_next_s;
                            pkt_cnt_q <= pkt_cnt_q + 16'd1;
                        end else begin
                            state_q <= ST_PASS;
                        end
                    end else begin
                        state_q <= ST_PASS;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
            if (wr_clr_s) begin
                pkt_cnt_q <= 16'd0;
                err_q     <= 1'b0;
            end
        end
    end

    pkt_skid_buf u_skid (
        .clk_i       (sys_clk_i),
        .rst_n_i     (sys_rst_n_i),
        .in_data_i   (sel_data_s),
        .in_valid_i  (pass_s & sel_valid_s),
        .in_ready_o  (skid_rdy_s),
        .out_data_o  (bus.out_data),
        .out_valid_o (bus.out_valid),
        .out_ready_i (bus.out_ready)
    );

    assign bus.in_ready = in_ready_s;
    assign bus.status   = {err_q, pass_s, 12'd0, grant_q, pkt_cnt_q};

endmodule

// File: tb/tb_umtrx_rx_pkt_mux.sv
// Directed bench for the RX packet mux: a table of packet scenarios plus
// hand-written reset, mask, protocol-error and reset-mid-packet sequences.
module tb_umtrx_rx_pkt_mux;

    logic clk;
    logic rst_n;

    umtrx_rx_pkt_mux_if #(.NUM_CHAN(2)) bus_if ();

    umtrx_rx_pkt_mux #(.NUM_CHAN(2), .BASE(0)) dut (
        .sys_clk_i   (clk),
        .sys_rst_n_i (rst_n),
        .bus         (bus_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mask;
        int         n0;
        int         n1;
        int         len;
        bit         rnd;
        int         exp_n;
        logic [7:0] exp_ch;   // bit j = channel of j-th output packet
    } vec_t;

    vec_t        vecs [6];
    logic [35:0] src_q0 [$];
    logic [35:0] src_q1 [$];
    logic [35:0] got_q  [$];
    int          got_eofs;
    int          acc_cnt [2];
    int          tests;
    int          fails;
    bit          rand_rdy;
    bit          ch0_rdy_seen;
    bit          stalled;
    logic [35:0] stall_data;

    function automatic logic [35:0] mkword(input int ch, input int pid, input int idx, input int len);
        logic [31:0] d;
        d = {4'(ch), 12'(pid), 16'(idx)};
        return {2'b00, (idx == len - 1), (idx == 0), d};
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, required %h", nm, act, exp);
        end
    endtask

    task automatic fill(input int ch, input int npkt, input int len, input int pid0);
        for (int p = 0; p < npkt; p++) begin
            for (int i = 0; i < len; i++) begin
                if (ch == 0) src_q0.push_back(mkword(ch, pid0 + p, i, len));
                else         src_q1.push_back(mkword(ch, pid0 + p, i, len));
            end
        end
    endtask

    task automatic drive_inputs();
        bus_if.in_valid[0]     = (src_q0.size() != 0);
        bus_if.in_data[35:0]   = (src_q0.size() != 0) ? src_q0[0] : 36'd0;
        bus_if.in_valid[1]     = (src_q1.size() != 0);
        bus_if.in_data[71:36]  = (src_q1.size() != 0) ? src_q1[0] : 36'd0;
    endtask

    // One clock: sample at negedge, let the edge happen, update sources after it
    task automatic cycle();
        bit a0, a1, rs;
        @(negedge clk);
        rs = rst_n;
        a0 = bus_if.in_valid[0] & bus_if.in_ready[0];
        a1 = bus_if.in_valid[1] & bus_if.in_ready[1];
        if (rs && bus_if.in_ready[0]) ch0_rdy_seen = 1'b1;
        if (stalled) check("stall_hold", {27'd0, bus_if.out_valid, bus_if.out_data}, {27'd0, 1'b1, stall_data});
        if (bus_if.out_valid && bus_if.out_ready) begin
            got_q.push_back(bus_if.out_data);
            if (bus_if.out_data[33]) got_eofs++;
        end
        stalled    = rs & bus_if.out_valid & ~bus_if.out_ready;
        stall_data = bus_if.out_data;
        @(posedge clk);
        #1;
        if (rs && a0) begin void'(src_q0.pop_front()); acc_cnt[0]++; end
        if (rs && a1) begin void'(src_q1.pop_front()); acc_cnt[1]++; end
        drive_inputs();
        bus_if.out_ready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic set_cfg(input logic [7:0] addr, input logic [31:0] data);
        bus_if.set_stb  = 1'b1;
        bus_if.set_addr = addr;
        bus_if.set_data = data;
        cycle();
        bus_if.set_stb  = 1'b0;
    endtask

    task automatic clear_env();
        src_q0.delete();
        src_q1.delete();
        got_q.delete();
        got_eofs     = 0;
        acc_cnt[0]   = 0;
        acc_cnt[1]   = 0;
        ch0_rdy_seen = 1'b0;
        stalled      = 1'b0;
        drive_inputs();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clear_env();
        repeat (3) cycle();
        rst_n = 1'b1;
        ch0_rdy_seen = 1'b0;
    endtask

    task automatic run_until(input string nm, input int n, input int budget);
        int k;
        k = 0;
        while (got_eofs < n && k < budget) begin
            cycle();
            k++;
        end
        tests++;
        if (got_eofs < n) begin
            fails++;
            $display("FAIL %s timeout: got %0d packets, required %0d", nm, got_eofs, n);
        end
        repeat (4) cycle();
    endtask

    // Rebuild the expected merged stream from the channel order and compare
    task automatic verify(input string nm, input int exp_n, input logic [7:0] exp_ch,
                          input int len0, input int len1);
        int pid [2];
        int pos, ln, total, c;
        pid[0] = 0;
        pid[1] = 0;
        total  = 0;
        for (int j = 0; j < exp_n; j++) total += exp_ch[j] ? len1 : len0;
        check({nm, " word_count"}, 64'(got_q.size()), 64'(total));
        pos = 0;
        for (int j = 0; j < exp_n; j++) begin
            c  = exp_ch[j] ? 1 : 0;
            ln = c ? len1 : len0;
            for (int i = 0; i < ln; i++) begin
                if (pos < got_q.size())
                    check($sformatf("%s pkt%0d word%0d", nm, j, i), 64'(got_q[pos]), 64'(mkword(c, pid[c], i, ln)));
                pos++;
            end
            pid[c]++;
        end
    endtask

    initial begin
        logic [35:0] bad_w;
        tests    = 0;
        fails    = 0;
        rand_rdy = 1'b0;
        rst_n    = 1'b0;
        bus_if.set_stb   = 1'b0;
        bus_if.set_addr  = 8'd0;
        bus_if.set_data  = 32'd0;
        bus_if.out_ready = 1'b1;
        bus_if.in_valid  = 2'b00;
        bus_if.in_data   = 72'd0;

        vecs[0] = '{2'b11, 2, 2,   4, 1'b0, 4, 8'b0000_1010};
        vecs[1] = '{2'b10, 2, 2,   4, 1'b0, 2, 8'b0000_0011};
        vecs[2] = '{2'b01, 2, 2,   4, 1'b0, 2, 8'b0000_0000};
        vecs[3] = '{2'b11, 3, 1,   1, 1'b0, 4, 8'b0000_0010};
        vecs[4] = '{2'b11, 0, 3,   3, 1'b1, 3, 8'b0000_0111};
        vecs[5] = '{2'b11, 1, 0, 100, 1'b1, 1, 8'b0000_0000};

        // Reset held with every source valid
        clear_env();
        fill(0, 1, 4, 0);
        fill(1, 1, 4, 0);
        drive_inputs();
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("rst out_valid", 64'(bus_if.out_valid), 64'd0);
            check("rst in_ready", 64'(bus_if.in_ready), 64'd0);
            check("rst status", 64'(bus_if.status), 64'd0);
        end
        rst_n = 1'b1;
        cycle();
        check("post_rst busy+grant", 64'(bus_if.status[31:16]), 64'h4000);
        check("post_rst in_ready", 64'(bus_if.in_ready), 64'd1);
        run_until("post_rst", 2, 100);
        verify("post_rst", 2, 8'b10, 4, 4);

        // Table-driven scenarios
        for (int v = 0; v < 6; v++) begin
            do_reset();
            if (vecs[v].mask != 2'b11) set_cfg(8'd0, {30'd0, vecs[v].mask});
            ch0_rdy_seen = 1'b0;
            fill(0, vecs[v].n0, vecs[v].len, 0);
            fill(1, vecs[v].n1, vecs[v].len, 0);
            drive_inputs();
            rand_rdy = vecs[v].rnd;
            run_until($sformatf("vec%0d", v), vecs[v].exp_n, 2000);
            rand_rdy = 1'b0;
            bus_if.out_ready = 1'b1;
            repeat (3) cycle();
            verify($sformatf("vec%0d", v), vecs[v].exp_n, vecs[v].exp_ch, vecs[v].len, vecs[v].len);
            check($sformatf("vec%0d pkt_count", v), 64'(bus_if.status[15:0]), 64'(vecs[v].exp_n));
            check($sformatf("vec%0d err", v), 64'(bus_if.status[31]), 64'd0);
            if (!vecs[v].mask[0]) check($sformatf("vec%0d ch0_ready", v), 64'(ch0_rdy_seen), 64'd0);
        end

        // Mask write in the middle of a ch0 packet
        do_reset();
        fill(0, 2, 8, 0);
        fill(1, 2, 4, 0);
        drive_inputs();
        for (int k = 0; k < 50 && acc_cnt[0] < 3; k++) cycle();
        check("mask mid ch0 words", 64'(acc_cnt[0] >= 3 && acc_cnt[0] < 8), 64'd1);
        set_cfg(8'd0, 32'h2);
        run_until("mask", 3, 200);
        verify("mask", 3, 8'b110, 8, 4);
        check("mask ch0 accepted", 64'(acc_cnt[0]), 64'd8);
        check("mask ch0 left", 64'(src_q0.size()), 64'd8);

        // SOF on the third word of a ch1 packet, then clear
        do_reset();
        fill(1, 1, 5, 0);
        bad_w = src_q1[2];
        bad_w[32] = 1'b1;
        src_q1[2] = bad_w;
        drive_inputs();
        run_until("proto", 1, 100);
        check("proto words", 64'(got_q.size()), 64'd5);
        if (got_q.size() == 5) check("proto bad word", 64'(got_q[2]), 64'(bad_w));
        check("proto err set", 64'(bus_if.status[31]), 64'd1);
        check("proto pkt_count", 64'(bus_if.status[15:0]), 64'd1);
        set_cfg(8'd1, 32'd0);
        check("clr err", 64'(bus_if.status[31]), 64'd0);
        check("clr pkt_count", 64'(bus_if.status[15:0]), 64'd0);

        // Reset after 2 words of an 8-word packet, with rr_ptr pointing at ch1
        do_reset();
        fill(0, 1, 4, 0);
        drive_inputs();
        run_until("rstmid pre", 1, 100);
        fill(0, 1, 8, 1);
        drive_inputs();
        for (int k = 0; k < 50 && acc_cnt[0] < 6; k++) cycle();
        check("rstmid words before rst", 64'(acc_cnt[0]), 64'd6);
        rst_n = 1'b0;
        cycle();
        check("rstmid out_valid", 64'(bus_if.out_valid), 64'd0);
        check("rstmid status", 64'(bus_if.status), 64'd0);
        check("rstmid in_ready", 64'(bus_if.in_ready), 64'd0);
        rst_n = 1'b1;
        clear_env();
        fill(0, 1, 2, 0);
        fill(1, 1, 2, 0);
        drive_inputs();
        run_until("rstmid post", 2, 100);
        verify("rstmid post", 2, 8'b10, 2, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
